seg_display_capture: RTL and testbench

Receive-side decoder for the four-digit multiplexed seven-segment bus driven by the counter display unit. It samples the segment and digit-select lines, waits for each pattern to settle, decodes the segment pattern back to a hex nibble per digit, and publishes a 16-bit value once all four digits have been seen in a frame. It sits on the capture side of the design, on the same clock as the display driver, and is used for loopback self-check and for reading display contents back into logic.

---
 rtl/seg_display_capture_if.sv | 21 ++
 rtl/seg_display_capture.sv | 139 +++++++++++++
 tb/tb_seg_display_capture.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_capture_if.sv
// Bundle of the seven-segment bus seen by the capture block and the
// decoded frame it publishes back to the surrounding logic.
interface seg_display_capture_if;
   logic [7:0]  segmentos;
   logic [3:0]  sel_seg;
   logic [15:0] value;
   logic [3:0]  dp_out;
   logic        frame_valid;
   logic        pattern_err;
   logic [7:0]  err_count;

   modport master (
      output segmentos, sel_seg,
      input  value, dp_out, frame_valid, pattern_err, err_count
   );

   modport slave (
      input  segmentos, sel_seg,
      output value, dp_out, frame_valid, pattern_err, err_count
   );
endinterface

// File: rtl/seg_display_capture.sv
// Receive-side decoder for a four-digit multiplexed seven-segment bus.
// Samples segments/selects, waits for a stable run, decodes each digit
// back to a hex nibble and publishes a 16-bit value per complete frame.
module seg_display_capture #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   seg_display_capture_if.slave bus
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);

   logic [11:0] samp_q;
   logic        primed_q;
   logic [7:0]  cnt_q;
   logic [15:0] slot_q, slot_d;
   logic [3:0]  slot_dp_q, slot_dp_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] value_q;
   logic [3:0]  dp_q;
   logic        fv_q, pe_q;
   logic [7:0]  errc_q;

   logic [11:0] raw_in;
   logic        same, commit, frame_done, err_hit;
   logic [7:0]  seg_n;
   logic [3:0]  sel_n;
   logic        dec_ok;
   logic [3:0]  dec_nib;

   // The sample register doubles as the held sample: the incoming bus is
   // compared against it, so the run count equals registered samples - 1.
   assign raw_in     = {bus.segmentos, bus.sel_seg};
   assign same       = primed_q && (raw_in == samp_q);
   assign commit     = same && (cnt_q == STABLE_PRE);
   assign seg_n      = SEG_ACTIVE_LOW ? ~samp_q[11:4] : samp_q[11:4];
   assign sel_n      = SEL_ACTIVE_LOW ? ~samp_q[3:0]  : samp_q[3:0];
   assign frame_done = (seen_q == 4'b1111);

   // Input sampling and stability run counter
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_q   <= '0;
         primed_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         samp_q   <= raw_in;
         primed_q <= 1'b1;
         if (!same)
            cnt_q <= '0;
         else if (cnt_q != STABLE_MAX)
            cnt_q <= cnt_q + 8'd1;
      end
   end

   // Segment pattern (gfedcba) to hex nibble
   always_comb begin
      dec_ok  = 1'b1;
      dec_nib = 4'h0;
      case (seg_n[6:0])
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h6F: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         default: dec_ok = 1'b0;
      endcase
   end

   // Commit handling; the frame clear is applied before any same-cycle commit
   always_comb begin
      slot_d    = slot_q;
      slot_dp_d = slot_dp_q;
      seen_d    = frame_done ? 4'b0000 : seen_q;
      err_hit   = 1'b0;
      if (commit && $onehot(sel_n)) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sel_n[i]) begin
               if (dec_ok) begin
                  slot_d[4*i +: 4] = dec_nib;
                  slot_dp_d[i]     = seg_n[7];
                  seen_d[i]        = 1'b1;
               end else begin
                  seen_d[i] = 1'b0;
                  err_hit   = 1'b1;
               end
            end
         end
      end
   end

   // Digit slots, frame publication and error accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q    <= '0;
         slot_dp_q <= '0;
         seen_q    <= '0;
         value_q   <= '0;
         dp_q      <= '0;
         fv_q      <= 1'b0;
         pe_q      <= 1'b0;
         errc_q    <= '0;
      end else begin
         slot_q    <= slot_d;
         slot_dp_q <= slot_dp_d;
         seen_q    <= seen_d;
         fv_q      <= frame_done;
         pe_q      <= err_hit;
         if (frame_done) begin
            value_q <= slot_q;
            dp_q    <= slot_dp_q;
         end
         if (err_hit && (errc_q != 8'hFF))
            errc_q <= errc_q + 8'd1;
      end
   end

   assign bus.value       = value_q;
   assign bus.dp_out      = dp_q;
   assign bus.frame_valid = fv_q;
   assign bus.pattern_err = pe_q;
   assign bus.err_count   = errc_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture with default parameters
// (STABLE_CYCLES=4, active-low selects, active-high segments).
module tb_seg_display_capture;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   fv_cnt = 0;
   int   pe_cnt = 0;
   logic [15:0] fv_value = '0;
   int   f0, p0;

   seg_display_capture_if bus_if ();

   seg_display_capture #(
      .STABLE_CYCLES (4),
      .SEL_ACTIVE_LOW(1'b1),
      .SEG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled 1 ns after each rising edge
   always @(posedge clk) begin
      #1;
      if (bus_if.frame_valid === 1'b1) begin
         fv_cnt++;
         fv_value = bus_if.value;
      end
      if (bus_if.pattern_err === 1'b1) pe_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a pattern at a falling edge so that exactly n rising edges sample it
   task automatic hold(input logic [7:0] s, input logic [3:0] l, input int n);
      @(negedge clk);
      bus_if.segmentos = s;
      bus_if.sel_seg   = l;
      repeat (n) @(posedge clk);
   endtask

   task automatic scan(input int d, input logic [7:0] s);
      logic [3:0] l;
      l = 4'b0001 << d;
      l = ~l;
      hold(s, l, 8);
      hold(8'h00, 4'hF, 2);
   endtask

   initial begin
      // Reset with random bus contents
      rst = 1'b1;
      bus_if.segmentos = 8'($urandom);
      bus_if.sel_seg   = 4'($urandom);
      for (int k = 0; k < 3; k++) hold(8'($urandom), 4'($urandom), 1);
      @(negedge clk);
      rst = 1'b0;
      bus_if.segmentos = 8'h00;
      bus_if.sel_seg   = 4'hF;
      @(posedge clk);
      #1;
      chk("rst_value", 32'(bus_if.value), 32'h0);
      chk("rst_dp", 32'(bus_if.dp_out), 32'h0);
      chk("rst_errc", 32'(bus_if.err_count), 32'h0);
      chk("rst_fv", 32'(bus_if.frame_valid), 32'h0);
      chk("rst_pe", 32'(bus_if.pattern_err), 32'h0);
      chk("rst_fv_pulses", 32'(fv_cnt), 32'h0);
      chk("rst_pe_pulses", 32'(pe_cnt), 32'h0);

      // Nominal scan with exact frame_valid latency on the last digit
      f0 = fv_cnt;
      scan(0, 8'h06);
      scan(1, 8'h5B);
      scan(2, 8'h4F);
      chk("nom_value_hold", 32'(bus_if.value), 32'h0);
      @(negedge clk);
      bus_if.segmentos = 8'h66;
      bus_if.sel_seg   = 4'b0111;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1 chk("nom_fv_early", 32'(bus_if.frame_valid), 32'h0);
      @(posedge clk);
      #1 chk("nom_fv_pulse", 32'(bus_if.frame_valid), 32'h1);
      chk("nom_value", 32'(bus_if.value), 32'h4321);
      chk("nom_dp", 32'(bus_if.dp_out), 32'h0);
      @(posedge clk);
      #1 chk("nom_fv_drop", 32'(bus_if.frame_valid), 32'h0);
      @(posedge clk);
      hold(8'h00, 4'hF, 2);
      chk("nom_fv_count", 32'(fv_cnt - f0), 32'h1);
      chk("nom_errc", 32'(bus_if.err_count), 32'h0);

      // Glitch: digit 0 shows 8 for only STABLE_CYCLES samples, then settles on 1
      f0 = fv_cnt;
      scan(1, 8'h5B);
      scan(2, 8'h4F);
      scan(3, 8'h66);
      hold(8'h7F, 4'b1110, 4);
      hold(8'h06, 4'b1110, 8);
      hold(8'h00, 4'hF, 2);
      chk("glitch_fv_count", 32'(fv_cnt - f0), 32'h1);
      chk("glitch_frame", 32'(fv_value), 32'h4321);
      chk("glitch_errc", 32'(bus_if.err_count), 32'h0);

      // Invalid pattern on digit 0 blocks the frame until rescanned
      f0 = fv_cnt;
      p0 = pe_cnt;
      @(negedge clk);
      bus_if.segmentos = 8'h49;
      bus_if.sel_seg   = 4'b1110;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 chk("inv_pe_early", 32'(bus_if.pattern_err), 32'h0);
      @(posedge clk);
      #1 chk("inv_pe_pulse", 32'(bus_if.pattern_err), 32'h1);
      chk("inv_errc", 32'(bus_if.err_count), 32'h1);
      @(posedge clk);
      #1 chk("inv_pe_drop", 32'(bus_if.pattern_err), 32'h0);
      repeat (2) @(posedge clk);
      hold(8'h00, 4'hF, 2);
      scan(1, 8'h5B);
      scan(2, 8'h4F);
      scan(3, 8'h66);
      chk("inv_no_frame", 32'(fv_cnt - f0), 32'h0);
      chk("inv_pe_count", 32'(pe_cnt - p0), 32'h1);
      scan(0, 8'h06);
      chk("inv_rescan_frame", 32'(fv_cnt - f0), 32'h1);
      chk("inv_rescan_value", 32'(bus_if.value), 32'h4321);
      chk("inv_errc_hold", 32'(bus_if.err_count), 32'h1);

      // Two selects active: no commit, seen bits survive
      f0 = fv_cnt;
      p0 = pe_cnt;
      scan(0, 8'h06);
      scan(1, 8'h5B);
      scan(2, 8'h4F);
      hold(8'h3F, 4'b1100, 10);
      hold(8'h00, 4'hF, 2);
      chk("multi_no_frame", 32'(fv_cnt - f0), 32'h0);
      chk("multi_no_pe", 32'(pe_cnt - p0), 32'h0);
      scan(3, 8'h66);
      chk("multi_frame", 32'(fv_cnt - f0), 32'h1);
      chk("multi_value", 32'(fv_value), 32'h4321);

      // Reset mid-frame discards partial digits; dp on digit 2
      scan(0, 8'h7D);
      scan(1, 8'h07);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("mid_rst_value", 32'(bus_if.value), 32'h0);
      chk("mid_rst_errc", 32'(bus_if.err_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      f0 = fv_cnt;
      scan(2, 8'hB9);
      scan(3, 8'h5E);
      chk("mid_rst_partial", 32'(fv_cnt - f0), 32'h0);
      scan(0, 8'h71);
      scan(1, 8'h77);
      chk("dp_frame", 32'(fv_cnt - f0), 32'h1);
      chk("dp_value", 32'(bus_if.value), 32'hDCAF);
      chk("dp_dp", 32'(bus_if.dp_out), 32'h4);

      // err_count saturation, alternating two undecodable patterns (incl. all-off)
      p0 = pe_cnt;
      for (int k = 0; k < 254; k++) hold((k % 2 == 1) ? 8'h00 : 8'h49, 4'b1110, 5);
      #1 chk("sat_errc_254", 32'(bus_if.err_count), 32'd254);
      for (int k = 254; k < 260; k++) hold((k % 2 == 1) ? 8'h00 : 8'h49, 4'b1110, 5);
      hold(8'h00, 4'hF, 2);
      chk("sat_errc_255", 32'(bus_if.err_count), 32'd255);
      chk("sat_pe_count", 32'(pe_cnt - p0), 32'd260);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
